// File: rtl/mfa_pkg.sv
// Shared types and the round-robin search used by the RAM port arbiters.
// Sized for up to eight requesters; arbiters zero-extend their request vectors.
package mfa_pkg;

    localparam int ADDR_LEN_DEF = 6;
    localparam int DATA_LEN_DEF = 8;
    localparam int ADDR_W_DEF   = ADDR_LEN_DEF + 1;
    localparam int MAX_REQ      = 8;
    localparam int IDX_W        = 3;

    // RAM address width is always one bit wider than ADDR_LEN.
    function automatic int addr_w(input int addr_len);
        return addr_len + 1;
    endfunction

    typedef struct packed {
        logic [ADDR_W_DEF-1:0]   addr;
        logic [DATA_LEN_DEF-1:0] data;
    } ram_req_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] next_ptr;
    } rr_res_t;

    // Search ptr, ptr+1, ... (mod n) for the first active request.
    function automatic rr_res_t rr_next(input logic [IDX_W-1:0] ptr,
                                        input logic [MAX_REQ-1:0] req,
                                        input int n);
        rr_res_t res;
        int      idx;
        res = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                idx = (int'(ptr) + k) % n;
                if (!res.found && req[idx]) begin
                    res.found    = 1'b1;
                    res.idx      = IDX_W'(idx);
                    res.next_ptr = IDX_W'((idx + 1) % n);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// Single round-robin arbiter: combinational one-hot grant, pointer advances
// past the winner. Grants are suppressed while reset is asserted.
module rr_arbiter
    import mfa_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    rr_res_t          res;

    always_comb begin
        res   = rr_next(ptr_q, MAX_REQ'(req), N);
        ptr_d = res.found ? res.next_ptr : ptr_q;
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_gnt
            assign gnt[gi] = !RST && res.found && (res.idx == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one write port and one registered read port of the matrix RAM between
// NUM_REQ requesters; read data is returned one cycle after grant, one-hot tagged.
module ram_port_arbiter
    import mfa_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_LEN = 6,
    parameter int DATA_LEN = 8
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic [NUM_REQ-1:0]                 wr_req,
    input  logic [NUM_REQ*(ADDR_LEN+1)-1:0]    wr_addr_in,
    input  logic [NUM_REQ*DATA_LEN-1:0]        wr_data_in,
    output logic [NUM_REQ-1:0]                 wr_gnt,
    input  logic [NUM_REQ-1:0]                 rd_req,
    input  logic [NUM_REQ*(ADDR_LEN+1)-1:0]    rd_addr_in,
    output logic [NUM_REQ-1:0]                 rd_gnt,
    output logic [NUM_REQ-1:0]                 rd_rsp_valid,
    output logic [DATA_LEN-1:0]                rd_rsp_data,
    output logic                               ram_wr_en,
    output logic [ADDR_LEN:0]                  ram_wr_addr,
    output logic [DATA_LEN-1:0]                ram_wr_data,
    output logic [ADDR_LEN:0]                  ram_rd_addr,
    input  logic [DATA_LEN-1:0]                ram_q
);

    localparam int ADDR_W = addr_w(ADDR_LEN);

    logic [NUM_REQ-1:0]  rsp_tag_q;
    logic [NUM_REQ-1:0]  rsp_tag_d;
    logic [ADDR_W-1:0]   wr_addr_sel [NUM_REQ];
    logic [DATA_LEN-1:0] wr_data_sel [NUM_REQ];
    logic [ADDR_W-1:0]   rd_addr_sel [NUM_REQ];

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .CLK (CLK),
        .RST (RST),
        .req (wr_req),
        .gnt (wr_gnt)
    );

    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .CLK (CLK),
        .RST (RST),
        .req (rd_req),
        .gnt (rd_gnt)
    );

    // Grants are one-hot, so masking each slice and OR-ing yields the mux.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_sel
            assign wr_addr_sel[gi] = wr_gnt[gi] ? wr_addr_in[gi*ADDR_W +: ADDR_W] : '0;
            assign wr_data_sel[gi] = wr_gnt[gi] ? wr_data_in[gi*DATA_LEN +: DATA_LEN] : '0;
            assign rd_addr_sel[gi] = rd_gnt[gi] ? rd_addr_in[gi*ADDR_W +: ADDR_W] : '0;
        end
    endgenerate

    always_comb begin
        ram_wr_addr = '0;
        ram_wr_data = '0;
        ram_rd_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ram_wr_addr = ram_wr_addr | wr_addr_sel[i];
            ram_wr_data = ram_wr_data | wr_data_sel[i];
            ram_rd_addr = ram_rd_addr | rd_addr_sel[i];
        end
    end

    assign ram_wr_en = |wr_gnt;
    assign rsp_tag_d = rd_gnt;

    // Tag tracks which requester owns the data the RAM presents next cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rsp_tag_q <= '0;
        end else begin
            rsp_tag_q <= rsp_tag_d;
        end
    end

    assign rd_rsp_valid = rsp_tag_q;
    assign rd_rsp_data  = ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios then random
// traffic, with read responses checked by a decoupled scoreboard monitor.
module tb_ram_port_arbiter;

    localparam int N  = 2;
    localparam int AW = 7;
    localparam int DL = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    wr_req, rd_req, wr_gnt, rd_gnt, rd_rsp_valid;
    logic [N*AW-1:0] wr_addr_in, rd_addr_in;
    logic [N*DL-1:0] wr_data_in;
    logic [DL-1:0]   rd_rsp_data, ram_wr_data, ram_q_tb;
    logic            ram_wr_en;
    logic [AW-1:0]   ram_wr_addr, ram_rd_addr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int            due;
        logic [N-1:0]  tag;
        logic [DL-1:0] data;
    } rsp_t;
    rsp_t sb[$];

    logic [DL-1:0] ref_mem [128];
    logic [DL-1:0] ram_mem [128];
    int ptr_w = 0;
    int ptr_r = 0;

    ram_port_arbiter #(.NUM_REQ(N), .ADDR_LEN(6), .DATA_LEN(DL)) dut (
        .CLK          (clk),
        .RST          (rst),
        .wr_req       (wr_req),
        .wr_addr_in   (wr_addr_in),
        .wr_data_in   (wr_data_in),
        .wr_gnt       (wr_gnt),
        .rd_req       (rd_req),
        .rd_addr_in   (rd_addr_in),
        .rd_gnt       (rd_gnt),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_data  (rd_rsp_data),
        .ram_wr_en    (ram_wr_en),
        .ram_wr_addr  (ram_wr_addr),
        .ram_wr_data  (ram_wr_data),
        .ram_rd_addr  (ram_rd_addr),
        .ram_q        (ram_q_tb)
    );

    always #5 clk = ~clk;

    // Environment RAM: synchronous write, registered read-before-write.
    always @(posedge clk) begin
        if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_wr_data;
        ram_q_tb <= ram_mem[ram_rd_addr];
        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Round-robin rule: first requester at or after the pointer, wrapping.
    task automatic rr_pick(input logic [N-1:0] req, input int ptr, output int idx);
        idx = -1;
        for (int k = 0; k < N; k++) begin
            if (idx < 0 && req[(ptr + k) % N]) idx = (ptr + k) % N;
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] wq, input logic [N-1:0] rq,
                        input logic [AW-1:0] wa0, input logic [DL-1:0] wd0,
                        input logic [AW-1:0] wa1, input logic [DL-1:0] wd1,
                        input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        int            wi, ri;
        logic [N-1:0]  eg_w, eg_r;
        logic [AW-1:0] wa [N];
        logic [DL-1:0] wd [N];
        logic [AW-1:0] ra [N];
        logic [AW-1:0] e_wa, e_ra;
        logic [DL-1:0] e_wd;
        rsp_t          e;
        wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1; ra[0] = ra0; ra[1] = ra1;
        if (r) sb.delete();
        rst = r; wr_req = wq; rd_req = rq;
        wr_addr_in = {wa1, wa0}; wr_data_in = {wd1, wd0}; rd_addr_in = {ra1, ra0};
        #1;
        if (r) begin
            wi = -1; ri = -1; ptr_w = 0; ptr_r = 0;
        end else begin
            rr_pick(wq, ptr_w, wi);
            rr_pick(rq, ptr_r, ri);
        end
        eg_w = (wi < 0) ? '0 : N'(1 << wi);
        eg_r = (ri < 0) ? '0 : N'(1 << ri);
        e_wa = (wi < 0) ? '0 : wa[wi];
        e_wd = (wi < 0) ? '0 : wd[wi];
        e_ra = (ri < 0) ? '0 : ra[ri];
        chk("wr_gnt", 32'(wr_gnt), 32'(eg_w));
        chk("rd_gnt", 32'(rd_gnt), 32'(eg_r));
        chk("ram_wr_en", 32'(ram_wr_en), 32'(wi >= 0));
        chk("ram_wr_addr", 32'(ram_wr_addr), 32'(e_wa));
        chk("ram_wr_data", 32'(ram_wr_data), 32'(e_wd));
        chk("ram_rd_addr", 32'(ram_rd_addr), 32'(e_ra));
        if (r) chk("rsp_valid_in_reset", 32'(rd_rsp_valid), 32'd0);
        $display("cycle %0d rst=%0b wr_req=%b rd_req=%b wr_gnt=%b rd_gnt=%b",
                 cyc, r, wq, rq, wr_gnt, rd_gnt);
        if (ri >= 0) begin
            e.due = cyc + 1; e.tag = eg_r; e.data = ref_mem[e_ra];
            sb.push_back(e);
            ptr_r = (ri + 1) % N;
        end
        if (wi >= 0) begin
            ref_mem[e_wa] = e_wd;
            ptr_w = (wi + 1) % N;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever a response is due.
    always @(negedge clk) begin
        rsp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("rsp_valid", 32'(rd_rsp_valid), 32'(e.tag));
            chk("rsp_data", 32'(rd_rsp_data), 32'(e.data));
        end else if (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            chk("rsp_overdue", 32'(cyc), 32'(e.due));
        end else begin
            chk("rsp_idle", 32'(rd_rsp_valid), 32'd0);
        end
    end

    initial begin
        for (int i = 0; i < 128; i++) begin
            ref_mem[i] = '0;
            ram_mem[i] = '0;
        end
        rst = 1'b1; wr_req = '0; rd_req = '0;
        wr_addr_in = '0; wr_data_in = '0; rd_addr_in = '0;
        @(posedge clk);
        #1;
        // Reset holds off writes even with both requesting.
        repeat (2) step(1, 2'b11, 2'b00, 7'd5, 8'h11, 7'd9, 8'h22, 7'd0, 7'd0);
        // Write fairness 01,10,01,10.
        repeat (4) step(0, 2'b11, 2'b00, 7'd5, 8'h11, 7'd9, 8'h22, 7'd0, 7'd0);
        // Requester 1 reads addr 9 -> 0x22; reset-time writes must not have landed.
        step(0, 2'b00, 2'b10, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0, 7'd9);
        step(0, 2'b00, 2'b01, 7'd0, 8'h00, 7'd0, 8'h00, 7'd5, 7'd0);
        // Concurrent same-address read/write returns the old value.
        step(0, 2'b01, 2'b00, 7'd3, 8'h07, 7'd0, 8'h00, 7'd0, 7'd0);
        step(0, 2'b01, 2'b10, 7'd3, 8'h55, 7'd0, 8'h00, 7'd0, 7'd3);
        step(0, 2'b00, 2'b10, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0, 7'd3);
        // Mid-flight reset drops the response and rewinds the pointers.
        step(0, 2'b00, 2'b01, 7'd0, 8'h00, 7'd0, 8'h00, 7'd5, 7'd0);
        step(1, 2'b00, 2'b00, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0, 7'd0);
        step(0, 2'b11, 2'b11, 7'd20, 8'hA0, 7'd21, 8'hA1, 7'd3, 7'd9);
        // Single requester streams without bubbles.
        repeat (5) step(0, 2'b00, 2'b10, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0, 7'd9);
        // Random traffic over a small address window to force collisions.
        for (int t = 0; t < 400; t++) begin
            step(0, N'($urandom_range(0, 3)), N'($urandom_range(0, 3)),
                 AW'($urandom_range(0, 15)), DL'($urandom),
                 AW'($urandom_range(0, 15)), DL'($urandom),
                 AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)));
        end
        repeat (2) step(0, 2'b00, 2'b00, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0, 7'd0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
